// File: rtl/coreaxi4dmacontroller_dscrptr_rd_master.sv
// AXI4 read master for external descriptor fetches. It issues one INCR burst per
// request and packs the returned 32-bit beats into a single descriptor word.
module coreaxi4dmacontroller_dscrptr_rd_master #(
   parameter int ID_WIDTH      = 1,
   parameter int ADDR_WIDTH    = 32,
   parameter int DSCRPTR_WIDTH = 133
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     rdReq,
   input  logic [ADDR_WIDTH-1:0]    rdAddr,
   output logic                     rdDone,
   output logic [1:0]               rdResp,
   output logic [DSCRPTR_WIDTH-1:0] rdDscrptr,
   output logic [ID_WIDTH-1:0]      ARID,
   output logic [ADDR_WIDTH-1:0]    ARADDR,
   output logic [7:0]               ARLEN,
   output logic [2:0]               ARSIZE,
   output logic [1:0]               ARBURST,
   output logic                     ARVALID,
   input  logic                     ARREADY,
   input  logic [31:0]              RDATA,
   input  logic [1:0]               RRESP,
   input  logic                     RLAST,
   input  logic                     RVALID,
   output logic                     RREADY
);

   localparam int NUM_BEATS = (DSCRPTR_WIDTH + 31) / 32;
   localparam int CNT_W     = $clog2(NUM_BEATS + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(NUM_BEATS - 1);
   localparam logic [CNT_W-1:0] BEAT_LIMIT = CNT_W'(NUM_BEATS);

   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      ADDR = 4'b0010,
      DATA = 4'b0100,
      DONE = 4'b1000
   } stateT;

   stateT state, nextState;
   logic [CNT_W-1:0] beatCnt;
   logic reqAccept;
   logic beatAccept;

   assign reqAccept  = (state == IDLE) && rdReq;
   assign beatAccept = (state == DATA) && RVALID;

   assign ARID    = '0;
   assign ARLEN   = 8'(NUM_BEATS - 1);
   assign ARSIZE  = 3'b010;
   assign ARBURST = 2'b01;

   // Handshake outputs decode straight from the one-hot state flops, so no AXI
   // input ever reaches an AXI output combinationally.
   assign ARVALID = (state == ADDR);
   assign RREADY  = (state == DATA);
   assign rdDone  = (state == DONE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (rdReq) nextState = ADDR;
         ADDR:    if (ARREADY) nextState = DATA;
         DATA:    if (RVALID && RLAST) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Beat counter saturates at NUM_BEATS so overrun beats are recognisable;
   // both a short burst and an overrun burst are reported as SLVERR.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ARADDR  <= '0;
         beatCnt <= '0;
         rdResp  <= 2'b00;
      end else if (reqAccept) begin
         ARADDR  <= rdAddr & ~ADDR_WIDTH'(3);
         beatCnt <= '0;
         rdResp  <= 2'b00;
      end else if (beatAccept) begin
         if (beatCnt < BEAT_LIMIT) beatCnt <= beatCnt + CNT_W'(1);
         if ((beatCnt >= BEAT_LIMIT) || (RLAST && (beatCnt < LAST_BEAT)))
            rdResp <= 2'b10;
         else
            rdResp <= rdResp | RRESP;
      end
   end

   // One storage slice per beat; the final slice keeps only the bits that fit.
   for (genvar n = 0; n < NUM_BEATS; n++) begin : gBeat
      localparam int LO = 32 * n;
      localparam int W  = ((DSCRPTR_WIDTH - LO) > 32) ? 32 : (DSCRPTR_WIDTH - LO);
      logic [W-1:0] word;

      always_ff @(posedge clock or posedge reset) begin
         if (reset)
            word <= '0;
         else if (reqAccept)
            word <= '0;
         else if (beatAccept && (beatCnt == CNT_W'(n)))
            word <= RDATA[W-1:0];
      end

      assign rdDscrptr[LO +: W] = word;
   end

endmodule

// File: doc/coreaxi4dmacontroller_dscrptr_rd_master.md
Name: coreaxi4dmacontroller_dscrptr_rd_master

Overview:
AXI4 read master that services external-descriptor fetch requests for the external descriptor fetch FSM. It accepts a held request carrying a descriptor base address and issues a single 5-beat INCR burst on the 32-bit AXI4 read channel. It packs the returned beats into a 133-bit descriptor and returns that descriptor with a one-cycle done pulse and an accumulated 2-bit response. The block sits between the fetch FSM and the controller's AXI4 master read port.

Parameters:
ID_WIDTH, 1, width of ARID/RID; ARID is driven all-zeros
ADDR_WIDTH, 32, AXI address width
DSCRPTR_WIDTH, 133, packed descriptor width; beat count NUM_BEATS = ceil(DSCRPTR_WIDTH/32) = 5

Ports:
clock  in  1  block clock; everything is rising-edge
reset  in  1  reset, asynchronous and active-high; one clock domain
rdReq  in  1  fetch request, level, held by requestor until rdDone
rdAddr  in  ADDR_WIDTH  descriptor base address, valid while rdReq high
rdDone  out  1  one-cycle pulse: descriptor and response valid
rdResp  out  2  accumulated AXI response of the burst
rdDscrptr  out  DSCRPTR_WIDTH  packed descriptor
ARID  out  ID_WIDTH  constant 0
ARADDR  out  ADDR_WIDTH  burst address
ARLEN  out  8  constant NUM_BEATS-1 (4)
ARSIZE  out  3  constant 3'b010
ARBURST  out  2  constant 2'b01 (INCR)
ARVALID  out  1  address valid
ARREADY  in  1  address ready
RDATA  in  32  read data
RRESP  in  2  read response
RLAST  in  1  last beat
RVALID  in  1  data valid
RREADY  out  1  data ready

Behaviour:
- Reset (asynchronous, any state): state IDLE; ARVALID, RREADY, rdDone = 0; rdResp = 0; rdDscrptr = 0; ARADDR = 0; beat counter = 0. An in-flight burst is abandoned; no recovery is attempted.
- FSM states: IDLE, ADDR, DATA, DONE. One-hot encoding.
- IDLE: if rdReq = 1, register ARADDR = {rdAddr[ADDR_WIDTH-1:2], 2'b00}, clear rdDscrptr, rdResp and the counter, then go to ADDR. ARVALID rises on the next cycle, so request-to-ARVALID latency is 1 cycle. rdReq is sampled only in IDLE.
- ADDR: ARVALID = 1 and ARADDR stays stable until ARREADY. On ARVALID & ARREADY, go to DATA with ARVALID low in that cycle.
- DATA: RREADY = 1. Each RVALID & RREADY beat does the following:
  - Beat n (n = 0..4) writes RDATA into rdDscrptr[32n+31:32n], truncated to DSCRPTR_WIDTH; beat 4 supplies only bits [132:128].
  - rdResp is updated as rdResp | RRESP, which is sticky.
  - The counter increments.
- DATA exits to DONE on a beat with RLAST = 1.
- Early RLAST (counter < 4): exit to DONE; unfilled descriptor bits stay 0; rdResp forced to 2'b10.
- Missing RLAST on beat 4: stay in DATA and keep RREADY high. Extra beats are accepted but not stored; rdResp is forced to 2'b10. Exit on RLAST.
- RID is ignored; only one burst is ever outstanding.
- DONE: rdDone = 1 for exactly one cycle, then IDLE. The requestor drops rdReq in the rdDone cycle, so a new request can be accepted from the cycle after DONE.
- rdDscrptr and rdResp hold their values from rdDone until the next accepted request.
- Throughput: minimum 8 cycles per fetch with zero-wait-state AXI (IDLE, ADDR, 5 DATA beats, DONE).
- All AXI outputs are registered; there is no combinational path from AXI inputs to AXI outputs.

Test Plan:
1. rdAddr=0x0000_1000, ARREADY=1, beats 0x11111111,0x22222222,0x33333333,0x44444444,0x0000001F with RRESP=0 and RLAST on beat 4. Required: ARADDR=0x1000, ARLEN=4, ARSIZE=2, ARBURST=1; rdDone 1 cycle after beat 4; rdDscrptr={5'h1F,0x44444444,0x33333333,0x22222222,0x11111111}; rdResp=0; 8 cycles request-to-done.
2. ARREADY held low 6 cycles. Required: ARVALID high and ARADDR stable throughout; burst proceeds after handshake.
3. Beat 2 RRESP=2'b10, others OKAY, RVALID gaps of 3 cycles. Required: rdResp=2'b10; all data still packed; no beat lost across gaps.
4. RLAST asserted on beat 2. Required: rdDone next cycle; rdDscrptr[132:96]=0; rdResp=2'b10. A following request with RLAST on beat 6 is fully drained with rdResp=2'b10.
5. Reset asserted in DATA after beat 1. Required: ARVALID, RREADY, rdDone, rdResp, rdDscrptr all 0 immediately (asynchronous); a new request after reset fetches normally.
6. rdAddr=0x0000_2003. Required: ARADDR=0x2000; two back-to-back requests each get exactly one rdDone pulse.
